// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC sequencing, one-cycle memory latency, and a one-entry skid
// buffer so a downstream stall never drops or duplicates an instruction.
module instruction_fetch #(
  parameter int unsigned        ADDR_W   = 6,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_rdata,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [15:0]       fetch_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              skid_valid_q;
  logic [31:0]       skid_data_q;
  logic [ADDR_W-1:0] skid_pc_q;
  logic              inst_valid_q;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic [15:0]       fetch_count_q;

  logic stall;
  logic xfer;
  logic issue;

  assign stall = inst_valid_q && !inst_ready;
  assign xfer  = inst_valid_q && inst_ready;
  // Issue is blocked while the skid holds data, so a return can never meet a full skid.
  assign issue = (state_q == StRun) && !redirect_valid && !halt_req && !stall && !skid_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_pc_q     <= '0;
      inst_valid_q  <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      fetch_count_q <= '0;
    end else if (redirect_valid) begin
      // Flush everything in flight; the output word is dropped without being counted.
      state_q      <= StRun;
      pc_q         <= redirect_pc;
      inflight_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle:  if (start) state_q <= StRun;
        StRun:   if (halt_req) state_q <= StHalt;
        default: ;
      endcase

      if (issue) begin
        pc_q          <= pc_q + ADDR_W'(1);
        inflight_pc_q <= pc_q;
      end
      inflight_q <= issue;

      if (inflight_q && !stall) begin
        inst_q       <= im_rdata;
        inst_pc_q    <= inflight_pc_q;
        inst_valid_q <= 1'b1;
      end else if (inflight_q) begin
        skid_data_q  <= im_rdata;
        skid_pc_q    <= inflight_pc_q;
        skid_valid_q <= 1'b1;
      end else if (skid_valid_q && !stall) begin
        inst_q       <= skid_data_q;
        inst_pc_q    <= skid_pc_q;
        inst_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (xfer) begin
        inst_valid_q <= 1'b0;
      end

      if (xfer && (fetch_count_q != 16'hFFFF)) begin
        fetch_count_q <= fetch_count_q + 16'd1;
      end
    end
  end

  assign im_addr     = pc_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;
  assign fetch_count = fetch_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios push expected PCs into a queue and an
// independent monitor checks every accepted instruction against it.
module tb_instruction_fetch;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          halt_req = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_rdata = '0;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [15:0]   fetch_count;
  logic [1:0]    state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_pc;

  instruction_fetch #(
    .ADDR_W   (AW),
    .RESET_PC (6'd0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .fetch_count    (fetch_count),
    .state          (state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [AW-1:0] a);
    return {8'hA5, 2'b00, a, 2'b00, a, 8'h3C};
  endfunction

  // Synchronous instruction memory: data for the sampled address appears after the edge.
  always @(posedge clk) im_rdata <= inst_of(im_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_range(input int first, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(AW'((first + i) % 64));
  endtask

  task automatic redirect_to(input logic [AW-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Monitor: sample just before the rising edge, once inputs have settled.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_xfer: got pc %0d, expected no transfer", inst_pc);
        end else begin
          mon_pc = exp_q.pop_front();
          check("xfer_pc", 32'(inst_pc), 32'(mon_pc));
          check("xfer_inst", inst, inst_of(mon_pc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", 32'(inst_pc), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);
    check("rst_addr", 32'(im_addr), 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("idle_no_fetch", 32'(im_addr), 32'd0);

    // Straight-line fetch with wrap; 66 issues then halt.
    push_range(0, 66);
    start = 1'b1;
    inst_ready = 1'b1;
    tick();
    start = 1'b0;
    check("run_state", 32'(state), 32'd1);
    check("edge0_valid", 32'(inst_valid), 32'd0);
    tick();
    check("edge1_valid", 32'(inst_valid), 32'd0);
    check("edge1_addr", 32'(im_addr), 32'd1);
    tick();
    check("edge2_valid", 32'(inst_valid), 32'd1);
    check("edge2_pc", 32'(inst_pc), 32'd0);
    tick(61);
    check("addr_63", 32'(im_addr), 32'd63);
    tick();
    check("addr_wrap", 32'(im_addr), 32'd0);
    tick(2);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_state", 32'(state), 32'd2);
    check("halt_addr", 32'(im_addr), 32'd2);
    tick(2);
    check("halt_drained", 32'(inst_valid), 32'd0);
    check("count_a", 32'(fetch_count), 32'd66);
    check("queue_a", 32'(exp_q.size()), 32'd0);

    // Three-cycle downstream stall mid-stream.
    push_range(10, 6);
    redirect_to(6'd10);
    check("redir_state", 32'(state), 32'd1);
    check("redir_addr", 32'(im_addr), 32'd10);
    tick(3);
    inst_ready = 1'b0;
    tick();
    check("stall_addr0", 32'(im_addr), 32'd13);
    check("stall_pc0", 32'(inst_pc), 32'd11);
    check("skid_full", 32'(dut.skid_valid_q), 32'd1);
    tick(2);
    check("stall_addr2", 32'(im_addr), 32'd13);
    check("stall_pc2", 32'(inst_pc), 32'd11);
    inst_ready = 1'b1;
    tick();
    check("skid_out_pc", 32'(inst_pc), 32'd12);
    check("skid_empty", 32'(dut.skid_valid_q), 32'd0);
    tick(3);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick(3);
    check("count_b", 32'(fetch_count), 32'd72);
    check("queue_b", 32'(exp_q.size()), 32'd0);

    // Redirect with two instructions in the pipe; both flushed and not counted.
    push_range(40, 3);
    redirect_to(6'd20);
    tick(2);
    check("pipe_valid", 32'(inst_valid), 32'd1);
    check("pipe_pc", 32'(inst_pc), 32'd20);
    redirect_to(6'd40);
    check("flush_valid", 32'(inst_valid), 32'd0);
    check("flush_addr", 32'(im_addr), 32'd40);
    check("flush_count", 32'(fetch_count), 32'd72);
    tick(2);
    check("target_pc", 32'(inst_pc), 32'd40);
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick(3);
    check("count_c", 32'(fetch_count), 32'd75);
    check("queue_c", 32'(exp_q.size()), 32'd0);

    // Halt during a stall: skid contents still drain while halted.
    push_range(5, 3);
    redirect_to(6'd5);
    check("resume_state", 32'(state), 32'd1);
    tick(3);
    inst_ready = 1'b0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt2_state", 32'(state), 32'd2);
    check("halt2_addr", 32'(im_addr), 32'd8);
    inst_ready = 1'b1;
    tick();
    check("halt_skid_pc", 32'(inst_pc), 32'd7);
    check("halt_skid_valid", 32'(inst_valid), 32'd1);
    tick(2);
    check("halt2_drained", 32'(inst_valid), 32'd0);
    check("halt2_addr_hold", 32'(im_addr), 32'd8);
    check("count_d", 32'(fetch_count), 32'd78);
    check("queue_d", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while stalled with the skid full.
    inst_ready = 1'b0;
    redirect_to(6'd30);
    tick(3);
    check("pre_rst_valid", 32'(inst_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(inst_valid), 32'd0);
    check("arst_inst", inst, 32'd0);
    check("arst_inst_pc", 32'(inst_pc), 32'd0);
    check("arst_count", 32'(fetch_count), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_addr", 32'(im_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    inst_ready = 1'b1;
    tick(3);
    check("post_rst_addr", 32'(im_addr), 32'd0);
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_valid", 32'(inst_valid), 32'd0);
    push_range(0, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    check("restart_valid", 32'(inst_valid), 32'd1);
    check("restart_pc", 32'(inst_pc), 32'd0);
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick(3);
    check("count_e", 32'(fetch_count), 32'd3);
    check("queue_e", 32'(exp_q.size()), 32'd0);

    // Counter saturation.
    force dut.fetch_count_q = 16'hFFFD;
    #1;
    release dut.fetch_count_q;
    push_range(50, 4);
    redirect_to(6'd50);
    tick(3);
    check("sat_fffe", 32'(fetch_count), 32'h0000FFFE);
    tick();
    check("sat_ffff", 32'(fetch_count), 32'h0000FFFF);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    check("sat_hold", 32'(fetch_count), 32'h0000FFFF);
    tick(2);
    check("queue_f", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
